sha256_msg_sched: RTL
=====================

// Module: sha256_msg_sched
// PURPOSE
//  Producer side of the compression core's W/ready interface: accepts one 512-bit padded block per handshake,
//  expands it to the 64-word message schedule (FIPS 180-4 6.2.2 step 1), then presents W[0:63] + ready to
//  core_pipe and holds them stable until the core's trigger (core_done). Sits between block padder and core.
// PARAMETERS
//  NUM_WORDS   64  schedule length (only default supported)
//  BLK_WORDS   16  words per input block (only default supported)
// PORTS
//  clk          in   1        system clock
//  reset        in   1        synchronous, active-high reset
//  blk_valid    in   1        upstream block valid
//  blk_ready    out  1        block accepted on clk edge when blk_valid & blk_ready
//  blk_data     in   512      padded block, big-endian: [511:480]=word0 ... [31:0]=word15
//  blk_last     in   1        block is last of its message (sampled with handshake)
//  W            out  64x32    schedule, [0:63][31:0], W[0] first
//  ready        out  1        to core: schedule valid; held continuously for whole compression
//  block_count  out  1        to core: 0 = first block of message, 1 = continuation block
//  core_done    in   1        from core trigger: compression finished, schedule may be released
// BEHAVIOUR
//  Reset (sync): state=IDLE, W=all 0, ready=0, block_count=0, idx=0, in_msg=0; blk_ready=0 while reset high.
//  blk_ready = (state==IDLE) & ~reset (combinational from state; no comb path from blk_valid).
//  FSM IDLE -> EXPAND -> HOLD -> IDLE:
//   IDLE:   handshake edge: W[0..15] <= blk_data words; W[16..63] untouched; idx <= 16;
//           block_count <= in_msg; in_msg <= ~blk_last; -> EXPAND. No handshake: hold.
//   EXPAND: each edge W[idx] <= s1(W[idx-2]) + W[idx-7] + s0(W[idx-15]) + W[idx-16] (mod 2^32,
//           carries dropped); idx++. Edge writing W[63] also sets ready<=1 and -> HOLD.
//           s0(x)=ROTR7^ROTR18^SHR3, s1(x)=ROTR17^ROTR19^SHR10.
//   HOLD:   W, ready, block_count frozen. core_done high at edge: ready<=0, -> IDLE
//           (blk_ready high next cycle).
//  Latency: handshake at edge 0 -> W[16] written edge 1 -> W[63] + ready=1 after edge 48.
//  Throughput: 1 block per (49 + core compression) cycles; no overlap (single W buffer).
//  Boundaries:
//   - core_done outside HOLD ignored; blk_valid outside IDLE ignored (blk_ready=0).
//   - core_done on edge that enters HOLD (EXPAND state) ignored; must arrive while in HOLD.
//   - blk_valid & blk_ready & blk_last on single-block message: block_count=0, in_msg back to 0.
//   - reset mid-EXPAND/HOLD: ready drops on that edge, partial schedule discarded, in_msg cleared.
//   - idx is 7 bits; never exceeds 63 in EXPAND; illegal state encodings -> IDLE, ready=0.
//  W may change only in IDLE (load) and EXPAND (indices >= 16 of current block); never while ready=1.
// STRUCTURE
//  sha256_pkg: ROTR, s0/s1 (small sigma), S0/S1, ch, maj functions; K[0:63] constant table;
//   H0 initial-hash constant; sched_state_t enum {IDLE, EXPAND, HOLD}. Shared with the compression core.
//  No sub-module: single always_ff (state, idx, W, ready, block_count, in_msg) + one comb
//   next-word expression using pkg functions and idx-indexed reads.
// TESTING
//  1 "abc" block (61626380, 0 x14, 00000018), last=1 -> W[16]=61626380, W[17]=000F0000,
//    W[63]=12B1EDEB; ready rises exactly 48 edges after handshake; block_count=0.
//  2 Hooked to core_pipe with H_in=sha256_pkg H0, "abc" -> H_out=BA7816BF...F20015AD at trigger;
//    ready falls edge after core_done; blk_ready high next cycle.
//  3 Two-block message (last=0 then last=1), then new single block -> block_count 0,1,0.
//  4 blk_valid held high during EXPAND/HOLD with changing blk_data -> no second load, W stable
//    (checker: W unchanged every cycle ready=1).
//  5 core_done pulsed in IDLE and EXPAND -> ignored; ready still asserted after edge 48.
//  6 reset asserted at idx=30 and during HOLD -> next cycle ready=0, W=0, blk_ready=1 one cycle
//    after reset deasserts; following "abc" block reproduces scenario 1 exactly.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: sigma/choice/majority helpers, round constants,
// initial hash value and the message-schedule FSM state type.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        HOLD   = 2'd2
    } sched_state_t;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [0:7][31:0] H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: loads one padded block, expands it to 64 words in
// place (one word per cycle), then holds W/ready for the compression core.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int NUM_WORDS = 64,
    parameter int BLK_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [511:0]      blk_data,
    input  logic              blk_last,
    output logic [0:63][31:0] W,
    output logic              ready,
    output logic              block_count,
    input  logic              core_done
);

    sched_state_t      r_state;
    logic [6:0]        r_idx;
    logic [0:63][31:0] r_w;
    logic              r_ready;
    logic              r_block_count;
    logic              r_in_msg;

    logic [5:0]        w_i;
    logic [31:0]       w_next;

    assign w_i    = r_idx[5:0];
    // Indices wrap in 6 bits but idx is always >= 16 while this is consumed.
    assign w_next = s1(r_w[w_i - 6'd2]) + r_w[w_i - 6'd7]
                  + s0(r_w[w_i - 6'd15]) + r_w[w_i - 6'd16];

    assign blk_ready   = (r_state == IDLE) && !reset;
    assign W           = r_w;
    assign ready       = r_ready;
    assign block_count = r_block_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_w           <= '0;
            r_ready       <= 1'b0;
            r_block_count <= 1'b0;
            r_in_msg      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (blk_valid && blk_ready) begin
                        for (int k = 0; k < BLK_WORDS; k++) begin
                            r_w[k] <= blk_data[511 - 32*k -: 32];
                        end
                        r_idx         <= 7'(BLK_WORDS);
                        r_block_count <= r_in_msg;
                        r_in_msg      <= ~blk_last;
                        r_state       <= EXPAND;
                    end
                end
                EXPAND: begin
                    r_w[w_i] <= w_next;
                    r_idx    <= r_idx + 7'd1;
                    if (r_idx == 7'(NUM_WORDS - 1)) begin
                        r_ready <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (core_done) begin
                        r_ready <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
